// File: rtl/tinysat_if.sv
// Tile pin bundle for the tiny SAT solver: 8 packed inputs, 8 packed outputs.
interface tinysat_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave (input io_in, output io_out);
endinterface

// File: rtl/tinysat_core.sv
// Brute-force SAT solver for 4-variable CNF formulas. Clauses are streamed in as
// signed literals while idle; a run request walks assignments 0..15, one per
// cycle, and stops on the first one satisfying every committed clause.
module tinysat_core #(
  parameter int MAX_CLAUSES = 8
) (
  tinysat_if.slave bus
);

  localparam int CW = $clog2(MAX_CLAUSES + 1);
  localparam int IW = (MAX_CLAUSES > 1) ? $clog2(MAX_CLAUSES) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  logic       clk;
  logic       rst;
  logic       run;
  logic       load;
  logic [4:0] data;

  assign clk  = bus.io_in[0];
  assign rst  = bus.io_in[1];
  assign run  = bus.io_in[2];
  assign load = bus.io_in[3];
  assign data = bus.io_in[7:3];

  state_t          state;
  state_t          state_next;
  logic [3:0]      x;
  logic            sol;
  logic [CW-1:0]   count;
  logic [3:0]      pos [MAX_CLAUSES];
  logic [3:0]      neg [MAX_CLAUSES];
  logic [3:0]      pend_pos;
  logic [3:0]      pend_neg;

  logic [4:0]      mag;
  logic            lit_valid;
  logic [3:0]      lit_bit;
  logic            room;
  logic            do_load;
  logic            do_commit;
  logic            sat;
  logic            start;
  logic            found;
  logic            exhaust;
  logic            step;

  // Decode the literal magnitude and decide whether this cycle loads or commits
  always_comb begin
    mag       = data[4] ? (~data + 5'd1) : data;
    lit_valid = (mag != 5'd0) && (mag <= 5'd4);
    lit_bit   = 4'b0001 << (mag[2:0] - 3'd1);
    room      = (count < CW'(MAX_CLAUSES));
    do_load   = (state == IDLE) && load && lit_valid && room;
    do_commit = (state == IDLE) && !load && !run && (data == 5'd0) &&
                ((pend_pos | pend_neg) != 4'b0000) && room;
  end

  // Formula is the AND of committed clauses; an empty store is trivially satisfied
  always_comb begin
    sat = 1'b1;
    for (int i = 0; i < MAX_CLAUSES; i++) begin
      if ((CW'(i) < count) && (((pos[i] & x) | (neg[i] & ~x)) == 4'b0000)) begin
        sat = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and search control; a load request outranks run while idle
  always_comb begin
    state_next = state;
    start      = 1'b0;
    found      = 1'b0;
    exhaust    = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (run && !load) begin
          state_next = SEARCH;
          start      = 1'b1;
        end
      end
      SEARCH: begin
        if (sat) begin
          state_next = DONE;
          found      = 1'b1;
        end else if (x == 4'hF) begin
          state_next = DONE;
          exhaust    = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (run) begin
          state_next = SEARCH;
          start      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Candidate assignment and solution flag; both freeze once the search ends
  always_ff @(posedge clk) begin
    if (rst) begin
      x   <= 4'h0;
      sol <= 1'b0;
    end else if (start) begin
      x   <= 4'h0;
      sol <= 1'b0;
    end else if (found) begin
      sol <= 1'b1;
    end else if (exhaust) begin
      sol <= 1'b0;
    end else if (step) begin
      x <= x + 4'h1;
    end
  end

  // Clause store: literals accumulate in the pending masks until a 0 terminator
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      pend_pos <= 4'b0000;
      pend_neg <= 4'b0000;
      for (int i = 0; i < MAX_CLAUSES; i++) begin
        pos[i] <= 4'b0000;
        neg[i] <= 4'b0000;
      end
    end else if (do_load) begin
      if (data[4]) begin
        pend_neg <= pend_neg | lit_bit;
      end else begin
        pend_pos <= pend_pos | lit_bit;
      end
    end else if (do_commit) begin
      pos[count[IW-1:0]] <= pend_pos;
      neg[count[IW-1:0]] <= pend_neg;
      count              <= count + CW'(1);
      pend_pos           <= 4'b0000;
      pend_neg           <= 4'b0000;
    end
  end

  assign bus.io_out = {2'b00, (state == DONE), sol, x};

endmodule

// File: tb/tb_tinysat_core.sv
// Directed self-checking bench for tinysat_core. Inputs change and outputs are
// sampled on the falling clock edge, half a period away from the active edge.
module tb_tinysat_core;

  logic       clk;
  logic       rst;
  logic       run;
  logic [4:0] data;
  int         errors;
  int         checks;

  tinysat_if bus ();

  assign bus.io_in = {data, run, rst, clk};

  tinysat_core #(.MAX_CLAUSES(8)) dut (.bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [3:0] x_o    = bus.io_out[3:0];
  wire       sol_o  = bus.io_out[4];
  wire       done_o = bus.io_out[5];
  wire [1:0] hi_o   = bus.io_out[7:6];

  // One rising edge, then settle to the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    run  = 1'b0;
    data = 5'd0;
    tick();
    rst = 1'b0;
  endtask

  // Present one literal for a cycle; load follows data[0] on the pins
  task automatic put_lit(input int v);
    run  = 1'b0;
    data = 5'(v);
    tick();
    data = 5'd0;
  endtask

  task automatic end_clause();
    run  = 1'b0;
    data = 5'd0;
    tick();
  endtask

  // Pulse run and count rising edges until done, including the one sampling run
  task automatic run_wait(output int edges);
    data  = 5'd0;
    run   = 1'b1;
    tick();
    run   = 1'b0;
    edges = 1;
    while (!done_o && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic expect_result(input string name, input int edges,
                               input int exp_edges, input logic exp_sol,
                               input logic [3:0] exp_x);
    checks++;
    if (done_o !== 1'b1 || edges != exp_edges) begin
      errors++;
      $display("[TB] FAIL %s latency: done=%b edges=%0d, required done=1 edges=%0d",
               name, done_o, edges, exp_edges);
    end
    checks++;
    if (sol_o !== exp_sol) begin
      errors++;
      $display("[TB] FAIL %s sol: got %b, required %b", name, sol_o, exp_sol);
    end
    checks++;
    if (x_o !== exp_x) begin
      errors++;
      $display("[TB] FAIL %s x: got %b, required %b", name, x_o, exp_x);
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) tick();
    checks++;
    if (bus.io_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset io_out: got %h, required 00", bus.io_out);
    end
  endtask

  task automatic test_empty();
    int e;
    do_reset();
    run_wait(e);
    expect_result("empty", e, 2, 1'b1, 4'b0000);
    checks++;
    if (hi_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL upper_bits: got %b, required 00", hi_o);
    end
  endtask

  // (x1|x3),(~x1): smallest solution has x1=0, x3=1 -> 4'b0100, found at edge 6
  task automatic test_two_clause();
    int e;
    do_reset();
    put_lit(1); put_lit(3); end_clause();
    put_lit(-1); end_clause();
    run_wait(e);
    expect_result("two_clause", e, 6, 1'b1, 4'b0100);
  endtask

  task automatic test_unsat();
    int e;
    do_reset();
    put_lit(1); end_clause();
    put_lit(-1); end_clause();
    run_wait(e);
    expect_result("unsat", e, 17, 1'b0, 4'hF);
  endtask

  // Even and out-of-range literals never land in the store; only (x1) remains
  task automatic test_ignored_literals();
    int e;
    do_reset();
    put_lit(2); end_clause();
    put_lit(-4); end_clause();
    put_lit(5); put_lit(-5); end_clause();
    put_lit(1); end_clause();
    run_wait(e);
    expect_result("ignored_lits", e, 3, 1'b1, 4'b0001);
  endtask

  // (x3),(x1) -> 4'b0101; result held in DONE, identical on a rerun
  task automatic test_back_to_back();
    int e;
    do_reset();
    put_lit(3); end_clause();
    put_lit(1); end_clause();
    run_wait(e);
    expect_result("first_run", e, 7, 1'b1, 4'b0101);
    repeat (3) tick();
    checks++;
    if (bus.io_out !== 8'h35) begin
      errors++;
      $display("[TB] FAIL done_hold: got %h, required 35", bus.io_out);
    end
    run_wait(e);
    expect_result("rerun", e, 7, 1'b1, 4'b0101);
  endtask

  task automatic test_reset_mid();
    int e;
    do_reset();
    put_lit(1); end_clause();
    put_lit(-1); end_clause();
    data = 5'd0;
    run  = 1'b1;
    tick();
    run = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.io_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL mid_reset io_out: got %h, required 00", bus.io_out);
    end
    run_wait(e);
    expect_result("after_reset", e, 2, 1'b1, 4'b0000);
  endtask

  // Seven (x1), an eighth (x3) that fits, a ninth (~x3) that is dropped
  task automatic test_overflow();
    int e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      put_lit(1); end_clause();
    end
    put_lit(3); end_clause();
    put_lit(-3); end_clause();
    run_wait(e);
    expect_result("overflow", e, 7, 1'b1, 4'b0101);
  endtask

  // A trailing literal with no terminator stays out of the formula
  task automatic test_stray_pending();
    int e;
    do_reset();
    put_lit(1); end_clause();
    put_lit(-1);
    run_wait(e);
    expect_result("stray", e, 3, 1'b1, 4'b0001);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    run    = 1'b0;
    data   = 5'd0;
    @(negedge clk);
    test_reset();
    test_empty();
    test_two_clause();
    test_unsat();
    test_ignored_literals();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    test_stray_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
